multi_port_banked_mem: RTL and testbench
========================================

# multi_port_banked_mem

Multi-port, multi-bank on-chip memory with per-bank round-robin arbitration and a valid/ready request interface. It generalises the single-port memory wrapper to NUM_PORTS concurrent requesters (e.g. compute-unit load/store lanes) sharing NUM_BANKS word-interleaved single-port banks. It returns one response per accepted request with fixed one-cycle latency. It sits between the core's memory lanes and the local scratchpad storage.

## Interface
- NUM_PORTS, 2: number of requester ports (1..8).
- DATAW, 32: word width in bits; must be a multiple of 8.
- BYTEENW, DATAW/8: byte-enable width.
- SIZE, 1024: total words; a multiple of NUM_BANKS.
- NUM_BANKS, 4: bank count; a power of two, at least 1.
- ADDRW, $clog2(SIZE): word address width.
- BANK_BITS, $clog2(NUM_BANKS): bank-select width; 0 when NUM_BANKS = 1.

Ports:
- clk_i  in  1  clock. One clock; all logic on the rising edge.
- rst_i  in  1  reset. Synchronous and active-high.
- req_valid_i  in  NUM_PORTS  request valid, one bit per port.
- req_ready_o  out  NUM_PORTS  request accepted this cycle.
- req_addr_i  in  NUM_PORTS*ADDRW  word address per port.
- req_wren_i  in  NUM_PORTS*BYTEENW  byte enables per port; all-zero means a read.
- req_wdata_i  in  NUM_PORTS*DATAW  write data per port.
- rsp_valid_o  out  NUM_PORTS  response valid.
- rsp_rdata_o  out  NUM_PORTS*DATAW  read data per port.

## Operation
- **Bank mapping:** word-interleaved. bank = addr[BANK_BITS-1:0]; row = addr[ADDRW-1:BANK_BITS]. Each bank holds SIZE/NUM_BANKS words and serves one access per cycle.
- **Arbitration:** each bank has an independent round-robin pointer rr[b] of width $clog2(NUM_PORTS).
  - Among ports with valid asserted and targeting bank b, the grant goes to the first port at or after rr[b], searching cyclically.
  - On a grant to port p, rr[b] becomes (p+1) mod NUM_PORTS on the next edge.
  - rr[b] is unchanged when bank b has no grant.
- **Ready:** req_ready_o[p] = granted[p] and not rst_i. It is combinational from valid and address. Requesters must not make valid depend on ready. Non-granted ports hold their request; there is no ordering between ports.
- **Write:** on an accepted request with non-zero byte enables, only the enabled bytes are written at that edge.
- **Read:** on an accepted all-zero byte-enable request, the word is read at that edge.
- **Response:**
  - rsp_valid_o[p] is 1 exactly one cycle after each accepted request, for reads and writes.
  - rsp_rdata_o[p] carries the read word for reads, and 0 for writes and whenever rsp_valid_o[p] = 0.
  - Responses cannot be backpressured.
- **Out-of-range address** (addr >= SIZE, possible only when SIZE is not a power of two): the request is accepted and arbitrated normally, a write is discarded, and a read returns 0.
- **Simultaneous events:**
  - Ports targeting different banks are all granted in the same cycle, up to NUM_BANKS grants per cycle.
  - Two ports targeting the same address in the same cycle are serialised by round-robin.
  - A write followed by a read to the same address on the next accepted cycle returns the new data.
- **Reset:**
  - rsp_valid_o = 0, rsp_rdata_o = 0 and all rr[b] = 0 on the edge with rst_i = 1.
  - req_ready_o = 0 while rst_i = 1, so no write occurs during reset.
  - A request accepted in the cycle before reset asserts produces no response.
  - Memory contents are not reset.

## Timing
- Request to response latency is exactly 1 cycle: accepted at edge N, rsp_valid_o high during cycle N+1.
- Full throughput is 1 request per port per cycle when ports target distinct banks. Contending ports see ready at least once every NUM_PORTS cycles per bank (starvation-free).
- The combinational path is valid/address -> bank decode -> arbiter -> ready. There is no combinational path from req inputs to rsp outputs.
- The first request is accepted in the first cycle after rst_i deasserts.

## Test plan
- **Reset values:** hold rst_i = 1 for 3 cycles with all ports valid -> req_ready_o = 0, rsp_valid_o = 0, rsp_rdata_o = 0, and no memory write (read-back of addr 5 afterwards is unchanged from its preload).
- **Write then read, single port:** port 0 writes 0xDEADBEEF to addr 5 with wren 4'b1111, then writes 0x000000AA with wren 4'b0001, then reads addr 5 -> rsp one cycle after each request, final rdata = 0xDEADBEAA.
- **Parallel, distinct banks:** port 0 reads addr 4 (bank 0) and port 1 reads addr 5 (bank 1) in the same cycle -> both ready = 1 and both rsp_valid next cycle with the correct data.
- **Round-robin on one bank:** both ports continuously read addr 8 for 6 cycles after reset -> grants alternate 0,1,0,1,0,1 and each port receives 3 responses.
- **Reset mid-operation:** assert rst_i in the cycle after port 1 is granted a read -> no rsp_valid for that read, and rr pointers return to 0 (port 0 wins the next contention).
- **Out of range, non-power-of-two size:** with SIZE = 12 and NUM_BANKS = 4, write 0x1234 to addr 13, then read addr 13 -> both accepted, read returns 0, and addr 1 contents are unchanged.

Source files
------------

// File: rtl/multi_port_banked_mem.sv
// multi_port_banked_mem
//
// Multi-port, word-interleaved banked scratchpad. NUM_PORTS requesters share
// NUM_BANKS single-port banks. Each bank has its own round-robin arbiter, so
// ports hitting different banks proceed in parallel and ports colliding on a
// bank are served fairly. Every accepted request (read or write) produces
// exactly one response one cycle later; responses cannot be stalled.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous, active-high reset
//   req_valid_i  per-port request valid
//   req_ready_o  per-port accept (combinational from valid/address)
//   req_addr_i   per-port word address, ADDRW bits each
//   req_wren_i   per-port byte enables; all zero selects a read
//   req_wdata_i  per-port write data
//   rsp_valid_o  per-port response valid, one cycle after acceptance
//   rsp_rdata_o  per-port read data; zero for writes and idle cycles
module multi_port_banked_mem #(
  parameter int NUM_PORTS = 2,
  parameter int DATAW     = 32,
  parameter int BYTEENW   = DATAW / 8,
  parameter int SIZE      = 1024,
  parameter int NUM_BANKS = 4,
  parameter int ADDRW     = $clog2(SIZE),
  parameter int BANK_BITS = $clog2(NUM_BANKS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_PORTS-1:0]           req_valid_i,
  output logic [NUM_PORTS-1:0]           req_ready_o,
  input  logic [NUM_PORTS*ADDRW-1:0]     req_addr_i,
  input  logic [NUM_PORTS*BYTEENW-1:0]   req_wren_i,
  input  logic [NUM_PORTS*DATAW-1:0]     req_wdata_i,
  output logic [NUM_PORTS-1:0]           rsp_valid_o,
  output logic [NUM_PORTS*DATAW-1:0]     rsp_rdata_o
);

  localparam int ROWS   = SIZE / NUM_BANKS;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int RR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BSEL_W = (NUM_BANKS > 1) ? BANK_BITS : 1;

  // Address decode is done on a 32-bit copy so that the in-range test stays
  // meaningful even when ADDRW is exactly wide enough for SIZE.
  function automatic logic [BSEL_W-1:0] bank_of(input logic [ADDRW-1:0] a);
    logic [31:0] a32;
    a32 = 32'(a);
    return BSEL_W'(a32 % NUM_BANKS);
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [ADDRW-1:0] a);
    logic [31:0] a32;
    a32 = 32'(a);
    return ROW_W'(a32 / NUM_BANKS);
  endfunction

  function automatic logic in_range(input logic [ADDRW-1:0] a);
    logic [31:0] a32;
    a32 = 32'(a);
    return a32 < SIZE;
  endfunction

  logic [BSEL_W-1:0]  p_bank  [NUM_PORTS];
  logic [ROW_W-1:0]   p_row   [NUM_PORTS];
  logic               p_inr   [NUM_PORTS];
  logic               p_rd    [NUM_PORTS];
  logic [BYTEENW-1:0] p_be    [NUM_PORTS];
  logic [DATAW-1:0]   p_wdata [NUM_PORTS];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      p_bank[p]  = bank_of(req_addr_i[p*ADDRW +: ADDRW]);
      p_row[p]   = row_of(req_addr_i[p*ADDRW +: ADDRW]);
      p_inr[p]   = in_range(req_addr_i[p*ADDRW +: ADDRW]);
      p_be[p]    = req_wren_i[p*BYTEENW +: BYTEENW];
      p_rd[p]    = (req_wren_i[p*BYTEENW +: BYTEENW] == '0);
      p_wdata[p] = req_wdata_i[p*DATAW +: DATAW];
    end
  end

  // Per-bank round-robin arbitration: search cyclically from rr_q[b] for the
  // first valid port addressing bank b.
  logic [RR_W-1:0]      rr_q          [NUM_BANKS];
  logic [RR_W-1:0]      bank_gnt_port [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_busy;
  logic [NUM_PORTS-1:0] gnt;
  logic [RR_W-1:0]      cand;

  always_comb begin
    gnt       = '0;
    bank_busy = '0;
    cand      = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_gnt_port[b] = '0;
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        cand = RR_W'((int'(rr_q[b]) + k) % NUM_PORTS);
        if (!bank_busy[b] && req_valid_i[cand] && (int'(p_bank[cand]) == b)) begin
          bank_busy[b]     = 1'b1;
          bank_gnt_port[b] = cand;
          gnt[cand]        = 1'b1;
        end
      end
    end
  end

  assign req_ready_o = gnt & {NUM_PORTS{~rst_i}};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        rr_q[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bank_busy[b]) begin
          rr_q[b] <= RR_W'((int'(bank_gnt_port[b]) + 1) % NUM_PORTS);
        end
      end
    end
  end

  // ---- stage p0 -> p1: bank access at the accepting edge ----
  logic [DATAW-1:0] bank_rd_p1 [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATAW-1:0] mem [ROWS];
    logic [DATAW-1:0] rd_p1;
    logic [RR_W-1:0]  sel;
    logic             acc;

    assign sel = bank_gnt_port[b];
    // Out-of-range requests are still granted, but never touch the array.
    assign acc = bank_busy[b] & ~rst_i & p_inr[sel];

    always_ff @(posedge clk_i) begin
      if (acc) begin
        if (p_rd[sel]) begin
          rd_p1 <= mem[p_row[sel]];
        end else begin
          for (int i = 0; i < BYTEENW; i++) begin
            if (p_be[sel][i]) begin
              mem[p_row[sel]][i*8 +: 8] <= p_wdata[sel][i*8 +: 8];
            end
          end
        end
      end
    end

    assign bank_rd_p1[b] = rd_p1;
  end

  logic [NUM_PORTS-1:0] vld_p1;
  logic [NUM_PORTS-1:0] rdq_p1;
  logic [BSEL_W-1:0]    bank_p1 [NUM_PORTS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1 <= '0;
    end else begin
      vld_p1 <= gnt;
    end
  end

  // Response steering: remember which bank served each port and whether the
  // response should carry data (in-range read) or zero.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rdq_p1[p]  <= p_rd[p] & p_inr[p];
      bank_p1[p] <= p_bank[p];
    end
  end

  // ---- stage p1: response outputs ----
  // Gating with rst_i drops a response whose request was accepted just
  // before reset asserted.
  always_comb begin
    rsp_valid_o = vld_p1 & {NUM_PORTS{~rst_i}};
    rsp_rdata_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rsp_valid_o[p] && rdq_p1[p]) begin
        rsp_rdata_o[p*DATAW +: DATAW] = bank_rd_p1[bank_p1[p]];
      end
    end
  end

endmodule

// File: tb/tb_multi_port_banked_mem.sv
`timescale 1ns/1ps
module tb_multi_port_banked_mem;

  localparam int NP  = 2;
  localparam int DW  = 32;
  localparam int BEW = 4;
  localparam int SZ  = 1024;
  localparam int NB  = 4;
  localparam int AW  = 10;
  localparam int SAW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [NP-1:0]      req_valid, req_ready, rsp_valid;
  logic [NP*AW-1:0]   req_addr;
  logic [NP*BEW-1:0]  req_wren;
  logic [NP*DW-1:0]   req_wdata, rsp_rdata;

  logic               v [NP];
  logic [AW-1:0]      a [NP];
  logic [BEW-1:0]     w [NP];
  logic [DW-1:0]      d [NP];

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      req_valid[p]           = v[p];
      req_addr[p*AW +: AW]   = a[p];
      req_wren[p*BEW +: BEW] = w[p];
      req_wdata[p*DW +: DW]  = d[p];
    end
  end

  multi_port_banked_mem #(
    .NUM_PORTS(NP), .DATAW(DW), .BYTEENW(BEW), .SIZE(SZ), .NUM_BANKS(NB), .ADDRW(AW), .BANK_BITS(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_wren_i(req_wren), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata)
  );

  // Second instance with a non-power-of-two size for out-of-range behaviour.
  logic               s_rst;
  logic [NP-1:0]      s_valid, s_ready, s_rsp_valid;
  logic [NP*SAW-1:0]  s_addr;
  logic [NP*BEW-1:0]  s_wren;
  logic [NP*DW-1:0]   s_wdata, s_rsp_rdata;

  multi_port_banked_mem #(
    .NUM_PORTS(NP), .DATAW(DW), .BYTEENW(BEW), .SIZE(12), .NUM_BANKS(4), .ADDRW(SAW), .BANK_BITS(2)
  ) dut_small (
    .clk_i(clk), .rst_i(s_rst),
    .req_valid_i(s_valid), .req_ready_o(s_ready),
    .req_addr_i(s_addr), .req_wren_i(s_wren), .req_wdata_i(s_wdata),
    .rsp_valid_o(s_rsp_valid), .rsp_rdata_o(s_rsp_rdata)
  );

  // Behavioural reference: flat word array, one rr pointer per bank,
  // and the responses owed for the next cycle.
  logic [DW-1:0]    mem_m [SZ];
  int               rr_m [NB];
  logic [NP-1:0]    exp_gnt, pend_vld, exp_vld;
  logic [DW-1:0]    pend_data [NP];
  logic [NP*DW-1:0] exp_rdata;
  int               n_checks, n_fail;

  task automatic model_eval();
    exp_gnt = '0;
    if (!rst) begin
      for (int b = 0; b < NB; b++) begin
        for (int k = 0; k < NP; k++) begin
          int p;
          p = (rr_m[b] + k) % NP;
          if (v[p] && (int'(a[p]) % NB) == b) begin
            exp_gnt[p] = 1'b1;
            break;
          end
        end
      end
    end
    exp_vld = rst ? '0 : pend_vld;
    for (int p = 0; p < NP; p++) exp_rdata[p*DW +: DW] = exp_vld[p] ? pend_data[p] : '0;
  endtask

  task automatic model_commit();
    logic [DW-1:0] nd [NP];
    if (rst) begin
      for (int b = 0; b < NB; b++) rr_m[b] = 0;
      pend_vld = '0;
      for (int p = 0; p < NP; p++) pend_data[p] = '0;
      return;
    end
    for (int p = 0; p < NP; p++) begin
      nd[p] = '0;
      if (exp_gnt[p] && w[p] == '0 && int'(a[p]) < SZ) nd[p] = mem_m[a[p]];
    end
    for (int p = 0; p < NP; p++) begin
      if (exp_gnt[p]) begin
        rr_m[int'(a[p]) % NB] = (p + 1) % NP;
        if (w[p] != '0 && int'(a[p]) < SZ)
          for (int i = 0; i < BEW; i++)
            if (w[p][i]) mem_m[a[p]][i*8 +: 8] = d[p][i*8 +: 8];
      end
    end
    pend_vld = exp_gnt;
    for (int p = 0; p < NP; p++) pend_data[p] = nd[p];
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int p = 0; p < NP; p++) begin
      v[p] = 1'b0; a[p] = '0; w[p] = '0; d[p] = '0;
    end
  endtask

  task automatic set_port(input int p, input logic vv, input logic [AW-1:0] aa,
                          input logic [BEW-1:0] ww, input logic [DW-1:0] dd);
    v[p] = vv; a[p] = aa; w[p] = ww; d[p] = dd;
  endtask

  task automatic preload();
    rst = 1'b0;
    for (int i = 0; i < SZ / 2; i++) begin
      set_port(0, 1'b1, AW'(2*i), 4'hF, $urandom);
      set_port(1, 1'b1, AW'(2*i + 1), 4'hF, $urandom);
      tick();
    end
    idle_all();
    tick();
  endtask

  task automatic test_reset();
    logic [DW-1:0] pre5;
    pre5 = mem_m[5];
    rst = 1'b1;
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, AW'(5), 4'hF, $urandom);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready c%0d: got %b want 00", c, req_ready); end
      n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid c%0d: got %b want 00", c, rsp_valid); end
      n_checks++; if (rsp_rdata !== '0) begin n_fail++; $display("FAIL reset_rsp_rdata c%0d: got %h want 0", c, rsp_rdata); end
      tick();
    end
    rst = 1'b0;
    idle_all();
    set_port(0, 1'b1, AW'(5), 4'h0, '0);
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL reset_first_accept: got %b want 01", req_ready); end
    tick();
    idle_all();
    #1;
    n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL reset_readback_vld: got %b want 01", rsp_valid); end
    n_checks++; if (rsp_rdata[31:0] !== pre5) begin n_fail++; $display("FAIL reset_readback_data: got %h want %h", rsp_rdata[31:0], pre5); end
    tick();
  endtask

  task automatic test_write_read();
    logic [BEW-1:0] be_t [4];
    logic [DW-1:0]  dt_t [4];
    logic           vt_t [4];
    be_t = '{4'hF, 4'h1, 4'h0, 4'h0};
    dt_t = '{32'hDEADBEEF, 32'h000000AA, 32'h0, 32'h0};
    vt_t = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 4; c++) begin
      idle_all();
      set_port(0, vt_t[c], AW'(5), be_t[c], dt_t[c]);
      #1; model_eval();
      n_checks++; if (req_ready !== exp_gnt) begin n_fail++; $display("FAIL wr_ready c%0d: got %b want %b", c, req_ready, exp_gnt); end
      n_checks++; if (rsp_valid !== exp_vld) begin n_fail++; $display("FAIL wr_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_vld); end
      n_checks++; if (rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL wr_rsp_rdata c%0d: got %h want %h", c, rsp_rdata, exp_rdata); end
      if (c == 3) begin
        n_checks++; if (rsp_rdata[31:0] !== 32'hDEADBEAA) begin n_fail++; $display("FAIL wr_final_data: got %h want deadbeaa", rsp_rdata[31:0]); end
      end
      tick();
    end
  endtask

  task automatic test_parallel();
    idle_all();
    set_port(0, 1'b1, AW'(4), 4'h0, '0);
    set_port(1, 1'b1, AW'(5), 4'h0, '0);
    #1;
    n_checks++; if (req_ready !== 2'b11) begin n_fail++; $display("FAIL par_ready: got %b want 11", req_ready); end
    tick();
    idle_all();
    #1;
    n_checks++; if (rsp_valid !== 2'b11) begin n_fail++; $display("FAIL par_rsp_valid: got %b want 11", rsp_valid); end
    n_checks++; if (rsp_rdata !== {mem_m[5], mem_m[4]}) begin n_fail++; $display("FAIL par_rsp_rdata: got %h want %h", rsp_rdata, {mem_m[5], mem_m[4]}); end
    tick();
  endtask

  task automatic test_round_robin();
    int cnt0, cnt1;
    cnt0 = 0; cnt1 = 0;
    idle_all();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 7; c++) begin
      idle_all();
      if (c < 6) begin
        set_port(0, 1'b1, AW'(8), 4'h0, '0);
        set_port(1, 1'b1, AW'(8), 4'h0, '0);
      end
      #1; model_eval();
      if (c < 6) begin
        n_checks++;
        if (req_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL rr_grant c%0d: got %b want %b", c, req_ready, (c % 2 == 0) ? 2'b01 : 2'b10); end
      end
      n_checks++; if (rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL rr_rdata c%0d: got %h want %h", c, rsp_rdata, exp_rdata); end
      cnt0 += int'(rsp_valid[0]);
      cnt1 += int'(rsp_valid[1]);
      tick();
    end
    n_checks++; if (cnt0 != 3 || cnt1 != 3) begin n_fail++; $display("FAIL rr_rsp_count: got %0d/%0d want 3/3", cnt0, cnt1); end
  endtask

  task automatic test_reset_mid();
    idle_all();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      idle_all();
      rst = (c == 2);
      if (c < 4) begin
        set_port(0, 1'b1, AW'(8), 4'h0, '0);
        set_port(1, 1'b1, AW'(8), 4'h0, '0);
      end
      #1; model_eval();
      n_checks++; if (req_ready !== exp_gnt) begin n_fail++; $display("FAIL rm_ready c%0d: got %b want %b", c, req_ready, exp_gnt); end
      n_checks++; if (rsp_valid !== exp_vld) begin n_fail++; $display("FAIL rm_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_vld); end
      if (c == 1) begin
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rm_p1_grant: got %b want 10", req_ready); end
      end
      if (c == 2 || c == 3) begin
        n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rm_dropped_rsp c%0d: got %b want 00", c, rsp_valid); end
      end
      if (c == 3) begin
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rm_rr_cleared: got %b want 01", req_ready); end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < NP; p++) begin
        v[p] = ($urandom_range(0, 3) != 0);
        a[p] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, SZ - 1)) : AW'($urandom_range(0, 15));
        w[p] = ($urandom_range(0, 1) == 0) ? 4'h0 : BEW'($urandom_range(0, 15));
        d[p] = $urandom;
      end
      #1; model_eval();
      n_checks++; if (req_ready !== exp_gnt) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready, exp_gnt); end
      n_checks++; if (rsp_valid !== exp_vld) begin n_fail++; $display("FAIL rnd_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_vld); end
      n_checks++; if (rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_rsp_rdata c%0d: got %h want %h", c, rsp_rdata, exp_rdata); end
      tick();
    end
    rst = 1'b0;
    idle_all();
    tick();
  endtask

  task automatic test_out_of_range();
    logic           sv_t [6];
    logic [SAW-1:0] sa_t [6];
    logic [BEW-1:0] sw_t [6];
    logic [DW-1:0]  sd_t [6];
    logic [NP-1:0]  rv_t [6];
    logic [DW-1:0]  rd_t [6];
    sv_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    sa_t = '{4'd1, 4'd13, 4'd13, 4'd1, 4'd0, 4'd0};
    sw_t = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    sd_t = '{32'h5555, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h0};
    rv_t = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    rd_t = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h5555, 32'h0};
    s_rst = 1'b1;
    s_valid = '0; s_addr = '0; s_wren = '0; s_wdata = '0;
    tick();
    s_rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      s_valid = {1'b0, sv_t[c]};
      s_addr  = {4'd0, sa_t[c]};
      s_wren  = {4'd0, sw_t[c]};
      s_wdata = {32'd0, sd_t[c]};
      #1;
      n_checks++; if (s_ready !== {1'b0, sv_t[c]}) begin n_fail++; $display("FAIL oor_ready c%0d: got %b want %b", c, s_ready, {1'b0, sv_t[c]}); end
      n_checks++; if (s_rsp_valid !== rv_t[c]) begin n_fail++; $display("FAIL oor_rsp_valid c%0d: got %b want %b", c, s_rsp_valid, rv_t[c]); end
      n_checks++; if (s_rsp_rdata[31:0] !== rd_t[c]) begin n_fail++; $display("FAIL oor_rsp_rdata c%0d: got %h want %h", c, s_rsp_rdata[31:0], rd_t[c]); end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; s_rst = 1'b1;
    s_valid = '0; s_addr = '0; s_wren = '0; s_wdata = '0;
    idle_all();
    for (int b = 0; b < NB; b++) rr_m[b] = 0;
    pend_vld = '0;
    for (int p = 0; p < NP; p++) pend_data[p] = '0;
    tick();
    tick();
    preload();
    test_reset();
    test_write_read();
    test_parallel();
    test_round_robin();
    test_reset_mid();
    test_random();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
